// File: rtl/router_reg_if.sv
// Bundle of the router datapath stage: FSM strobes and packet byte stream in,
// FIFO write byte and parity/status flags back out.
interface router_reg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pkt_valid;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;
  logic [DATA_WIDTH-1:0] dout;

  // master drives the byte stream and FSM strobes
  modport master (
    output data_in, pkt_valid, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  data_in, pkt_valid, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, forwards or stalls packet
// bytes toward the output FIFOs, and checks the running XOR parity of each packet.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  router_reg_if.slave bus
);

  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic [DATA_WIDTH-1:0] header_byte_reg, header_byte_next;
  logic [DATA_WIDTH-1:0] hold_byte_reg, hold_byte_next;
  logic [DATA_WIDTH-1:0] int_parity_reg, int_parity_next;
  logic [DATA_WIDTH-1:0] pkt_parity_reg, pkt_parity_next;
  logic                  parity_done_reg, parity_done_next;
  logic                  low_pkt_valid_reg, low_pkt_valid_next;
  logic                  err_reg, err_next;

  logic header_ok;
  logic ld_go;
  logic ld_stall;
  logic parity_late;

  // address 2'b11 is not a valid port, so such a header is never latched
  assign header_ok   = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
  assign ld_go       = bus.ld_state && !bus.fifo_full;
  assign ld_stall    = bus.ld_state && bus.fifo_full;
  // parity byte arrived while the FIFO was full; it is taken on the way out of the stall
  assign parity_late = bus.laf_state && low_pkt_valid_reg && !parity_done_reg;

  always_comb begin
    dout_next          = dout_reg;
    header_byte_next   = header_byte_reg;
    hold_byte_next     = hold_byte_reg;
    int_parity_next    = int_parity_reg;
    pkt_parity_next    = pkt_parity_reg;
    parity_done_next   = parity_done_reg;
    low_pkt_valid_next = low_pkt_valid_reg;
    err_next           = err_reg;

    if (header_ok)
      header_byte_next = bus.data_in;

    if (bus.lfd_state)
      dout_next = header_byte_reg;
    else if (ld_go)
      dout_next = bus.data_in;
    else if (ld_stall)
      hold_byte_next = bus.data_in;
    else if (bus.laf_state)
      dout_next = hold_byte_reg;

    // the trailing parity byte (pkt_valid low) is never folded in
    if (bus.detect_add)
      int_parity_next = '0;
    else if (bus.lfd_state)
      int_parity_next = int_parity_reg ^ header_byte_reg;
    else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
      int_parity_next = int_parity_reg ^ bus.data_in;

    if ((bus.ld_state && !bus.pkt_valid) || parity_late)
      pkt_parity_next = bus.data_in;
    else if (bus.detect_add)
      pkt_parity_next = '0;

    if ((ld_go && !bus.pkt_valid) || parity_late)
      parity_done_next = 1'b1;
    else if (bus.detect_add)
      parity_done_next = 1'b0;

    if (bus.rst_int_reg)
      low_pkt_valid_next = 1'b0;
    else if (bus.ld_state && !bus.pkt_valid)
      low_pkt_valid_next = 1'b1;

    if (bus.detect_add)
      err_next = 1'b0;
    else if (parity_done_reg)
      err_next = (int_parity_reg != pkt_parity_reg);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_reg          <= '0;
      header_byte_reg   <= '0;
      hold_byte_reg     <= '0;
      int_parity_reg    <= '0;
      pkt_parity_reg    <= '0;
      parity_done_reg   <= 1'b0;
      low_pkt_valid_reg <= 1'b0;
      err_reg           <= 1'b0;
    end else begin
      dout_reg          <= dout_next;
      header_byte_reg   <= header_byte_next;
      hold_byte_reg     <= hold_byte_next;
      int_parity_reg    <= int_parity_next;
      pkt_parity_reg    <= pkt_parity_next;
      parity_done_reg   <= parity_done_next;
      low_pkt_valid_reg <= low_pkt_valid_next;
      err_reg           <= err_next;
    end
  end

  assign bus.dout          = dout_reg;
  assign bus.parity_done   = parity_done_reg;
  assign bus.low_pkt_valid = low_pkt_valid_reg;
  assign bus.err           = err_reg;

  // the controlling FSM is in at most one state at a time
  strobe_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0({bus.detect_add, bus.lfd_state, bus.ld_state,
              bus.laf_state, bus.full_state, bus.rst_int_reg}));

endmodule

// File: tb/tb_router_reg.sv
// Packet-level bench for router_reg: an FSM-like driver sends whole packets and
// queues the expected outputs; a monitor pops and compares after each clock edge.
module tb_router_reg;

  typedef logic [7:0] byte_q_t[$];
  typedef enum int {K_IDLE, K_DET, K_LFD, K_LD, K_FULL, K_LAF, K_CHK} kind_e;
  typedef struct {
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
    string      tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  router_reg_if #(.DATA_WIDTH(8)) bus ();

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // packet-level reference state
  logic [7:0] m_header, m_hold, m_dout;
  logic       m_pd, m_lpv, m_err, m_bad;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk8({e.tag, ".dout"}, bus.dout, e.dout);
        chk1({e.tag, ".parity_done"}, bus.parity_done, e.pd);
        chk1({e.tag, ".low_pkt_valid"}, bus.low_pkt_valid, e.lpv);
        chk1({e.tag, ".err"}, bus.err, e.err);
      end
    end
  end

  task automatic drive_idle();
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_reg = 1'b0;
    bus.pkt_valid   = 1'b0;
    bus.fifo_full   = 1'b0;
    bus.data_in     = 8'h00;
  endtask

  // One FSM-phase cycle: drive it, then queue what the outputs must be after the edge.
  task automatic step(input kind_e k, input logic [7:0] d, input logic pv,
                      input logic ff, input string tag);
    exp_t e;
    logic [7:0] nd;
    logic npd, nlpv, nerr;
    @(negedge clock);
    bus.detect_add  = (k == K_DET);
    bus.lfd_state   = (k == K_LFD);
    bus.ld_state    = (k == K_LD);
    bus.laf_state   = (k == K_LAF);
    bus.full_state  = (k == K_FULL);
    bus.rst_int_reg = (k == K_CHK);
    bus.data_in     = d;
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    nd   = m_dout;
    npd  = m_pd;
    nlpv = m_lpv;
    // err reflects the packet verdict once parity_done has been seen
    nerr = (k == K_DET) ? 1'b0 : (m_pd ? m_bad : m_err);
    case (k)
      K_DET: begin
        if (pv && d[1:0] != 2'b11) m_header = d;
        npd = 1'b0;
      end
      K_LFD: nd = m_header;
      K_LD: begin
        if (ff) m_hold = d;
        else    nd = d;
        if (!pv) begin
          nlpv = 1'b1;
          if (!ff) npd = 1'b1;
        end
      end
      K_LAF: begin
        nd = m_hold;
        if (m_lpv && !m_pd) npd = 1'b1;
      end
      K_CHK: nlpv = 1'b0;
      default: ;
    endcase
    m_dout = nd;
    m_pd   = npd;
    m_lpv  = nlpv;
    m_err  = nerr;
    e.dout = nd; e.pd = npd; e.lpv = nlpv; e.err = nerr; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic stall_cycles();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++)
      step(K_FULL, 8'($urandom), 1'b1, 1'b1, "full");
  endtask

  task automatic send_packet(input logic [7:0] hdr, input byte_q_t pl, input logic [7:0] par,
                             input int stall_idx, input bit rnd_stall, input bit par_full);
    logic [7:0] acc;
    bit st;
    acc = hdr;
    foreach (pl[i]) acc ^= pl[i];
    m_bad = (acc != par);
    step(K_DET, hdr, 1'b1, 1'b0, "det");
    step(K_LFD, 8'($urandom), 1'b1, 1'b0, "lfd");
    foreach (pl[i]) begin
      st = (i == stall_idx) || (rnd_stall && $urandom_range(0, 3) == 0);
      step(K_LD, pl[i], 1'b1, st, "ld");
      if (st) begin
        stall_cycles();
        step(K_LAF, 8'($urandom), 1'b1, 1'b0, "laf");
      end
    end
    step(K_LD, par, 1'b0, par_full, "ld_par");
    if (par_full) begin
      stall_cycles();
      step(K_LAF, par, 1'b0, 1'b0, "laf_par");
    end
    step(K_CHK, 8'($urandom), 1'b0, 1'b0, "chk");
    step(K_IDLE, 8'($urandom), 1'b0, 1'b0, "idle");
    step(K_IDLE, 8'($urandom), 1'b0, 1'b0, "idle");
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    exp_t e;
    @(negedge clock);
    drive_idle();
    #2 reset = 1'b1;
    #1;
    chk8("async_rst.dout", bus.dout, 8'h00);
    chk1("async_rst.parity_done", bus.parity_done, 1'b0);
    chk1("async_rst.low_pkt_valid", bus.low_pkt_valid, 1'b0);
    chk1("async_rst.err", bus.err, 1'b0);
    m_header = 8'h00; m_hold = 8'h00; m_dout = 8'h00;
    m_pd = 1'b0; m_lpv = 1'b0; m_err = 1'b0;
    e.dout = 8'h00; e.pd = 1'b0; e.lpv = 1'b0; e.err = 1'b0; e.tag = "rst_held";
    exp_q.push_back(e);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin : driver
    byte_q_t pl;
    logic [7:0] hdr, par;
    int len;
    drive_idle();
    m_header = 8'h00; m_hold = 8'h00; m_dout = 8'h00;
    m_pd = 1'b0; m_lpv = 1'b0; m_err = 1'b0; m_bad = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk8("por.dout", bus.dout, 8'h00);
    chk1("por.parity_done", bus.parity_done, 1'b0);
    chk1("por.low_pkt_valid", bus.low_pkt_valid, 1'b0);
    chk1("por.err", bus.err, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // good packet, then the same packet with a wrong parity byte
    pl = {}; pl.push_back(8'h11); pl.push_back(8'h22);
    send_packet(8'h05, pl, 8'h36, -1, 1'b0, 1'b0);
    send_packet(8'h05, pl, 8'h37, -1, 1'b0, 1'b0);

    // payload byte AA arrives while the FIFO is full
    pl = {}; pl.push_back(8'h11); pl.push_back(8'hAA); pl.push_back(8'h22);
    send_packet(8'h06, pl, 8'h9F, 1, 1'b0, 1'b0);

    // parity byte 5C arrives while the FIFO is full
    pl = {}; pl.push_back(8'h5D);
    send_packet(8'h01, pl, 8'h5C, -1, 1'b0, 1'b1);

    // reset in the middle of the payload, then a clean packet
    step(K_DET, 8'h42, 1'b1, 1'b0, "det");
    step(K_LFD, 8'h00, 1'b1, 1'b0, "lfd");
    step(K_LD, 8'hC3, 1'b1, 1'b0, "ld");
    async_reset();
    pl = {}; pl.push_back(8'h11); pl.push_back(8'h22);
    send_packet(8'h05, pl, 8'h36, -1, 1'b0, 1'b0);

    // address 3 header must not replace the latched header
    step(K_DET, 8'h07, 1'b1, 1'b0, "det_addr3");
    step(K_LFD, 8'h00, 1'b1, 1'b0, "lfd_after_addr3");

    for (int n = 0; n < 40; n++) begin
      hdr = {6'($urandom), 2'($urandom_range(0, 2))};
      if ($urandom_range(0, 4) == 0)
        step(K_DET, {6'($urandom), 2'b11}, 1'b1, 1'b0, "det_addr3");
      if ($urandom_range(0, 9) == 0) begin
        step(K_DET, hdr, 1'b1, 1'b0, "det");
        step(K_LFD, 8'($urandom), 1'b1, 1'b0, "lfd");
        step(K_LD, 8'($urandom), 1'b1, 1'b0, "ld");
        async_reset();
      end
      len = $urandom_range(1, 6);
      pl = {};
      par = hdr;
      for (int i = 0; i < len; i++) begin
        pl.push_back(8'($urandom));
        par ^= pl[i];
      end
      if ($urandom_range(0, 2) == 0) par ^= 8'(1 << $urandom_range(0, 7));
      send_packet(hdr, pl, par, -1, 1'b1, $urandom_range(0, 2) == 0);
    end

    repeat (3) @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
